pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Per-core instruction sequencer. Owns the PC register and steps the core through
//  FETCH/DECODE/EXECUTE/UPDATE. Drives the next-PC select (branch vs PC+1) into PC_MuxTwo.
//  Sits between program-memory fetch port, decoder/NZP branch logic and execute units.
// PARAMETERS
//  PC_WIDTH     8        program counter width; PC arithmetic is modulo 2**PC_WIDTH
//  INSTR_WIDTH  16       instruction word width
//  START_PC     '0       PC loaded on reset and on each Start
// PORTS
//  clk            in   1            core clock, all state on rising edge
//  rst_n          in   1            asynchronous, active-low reset
//  Start          in   1            launch program (sampled in IDLE/DONE only)
//  FetchReq       out  1            fetch request, held until FetchValid
//  FetchAddr      out  PC_WIDTH     address for fetch = CurrentPC
//  FetchValid     in   1            fetch data valid this cycle
//  FetchInstr     in   INSTR_WIDTH  fetched instruction
//  Instr          out  INSTR_WIDTH  latched instruction for decoder
//  IsBranch       in   1            decoder: instruction is conditional branch (valid from DECODE)
//  BranchTaken    in   1            NZP condition met (valid in EXECUTE)
//  BranchTarget   in   PC_WIDTH     branch target (valid in EXECUTE)
//  IsRet          in   1            decoder: halt/return instruction
//  ExecDone       in   1            execute units finished (ALU/LSU)
//  PCMux          out  1            1 = select Branch, 0 = CurrentPCPlus
//  Branch         out  PC_WIDTH     latched branch target to mux
//  CurrentPCPlus  out  PC_WIDTH     CurrentPC + 1 (wraps)
//  CurrentPC      out  PC_WIDTH     architectural PC
//  Done           out  1            program complete, sticky until Start
//  State          out  3            encoded FSM state (debug)
// BEHAVIOUR
//  Reset (async, rst_n=0): State=IDLE, CurrentPC=START_PC, Instr=0, Branch=0, PCMux=0,
//   FetchReq=0, Done=0. Reset mid-operation aborts any fetch/execute immediately.
//  IDLE: Start=1 -> CurrentPC<=START_PC, go FETCH. Otherwise stay.
//  FETCH: FetchReq=1 combinationally; on FetchValid: Instr<=FetchInstr, go DECODE
//   (FetchReq drops next cycle). No FetchValid -> stay, FetchAddr stable.
//  DECODE: one cycle; go EXECUTE.
//  EXECUTE: on each cycle latch Branch<=BranchTarget, take<=IsBranch&BranchTaken;
//   when ExecDone=1 go UPDATE (ExecDone in first EXECUTE cycle -> 1-cycle EXECUTE).
//  UPDATE: PCMux=take; CurrentPC<=NextPC from PC_MuxTwo. IsRet=1 -> DONE
//   (PC still updated), else FETCH. take cleared on leaving UPDATE.
//  DONE: Done=1; Start=1 -> Done<=0, CurrentPC<=START_PC, go FETCH.
//  PCMux is 0 in every state except UPDATE.
//  Start outside IDLE/DONE is ignored. FetchValid outside FETCH ignored.
//  CurrentPCPlus = CurrentPC+1 truncated to PC_WIDTH (all-ones wraps to 0).
//  Min latency per non-stalled instruction: 4 cycles (FETCH,DECODE,EXECUTE,UPDATE).
//  IsBranch&IsRet both set: branch select still applies, then DONE.
// STRUCTURE
//  Package gpu_core_pkg: typedef enum logic [2:0] {IDLE,FETCH,DECODE,EXECUTE,UPDATE,DONE}
//   core_state_t; shared with decoder/LSU for state-qualified enables.
//  Sub-module: instantiate PC_MuxTwo (PC_WIDTH passthrough) for NextPC; FSM + PC reg local.
// TESTING
//  1 Reset then Start, FetchValid 1 cycle after req, ExecDone immediate, 3 non-branch
//    instrs -> FetchAddr 0,1,2; 4 cycles/instr; PCMux stays 0.
//  2 Branch at PC=5, BranchTaken=1, target=0x20 -> PCMux=1 only in UPDATE, next FetchAddr=0x20;
//    same with BranchTaken=0 -> next FetchAddr=6.
//  3 PC=0xFF non-branch (PC_WIDTH=8) -> CurrentPCPlus=0x00, next FetchAddr=0x00.
//  4 FetchValid delayed 5 cycles, ExecDone delayed 3 -> FetchReq/FetchAddr stable, State held.
//  5 IsRet at PC=3 -> Done=1, FetchReq=0 thereafter; Start -> Done=0, FetchAddr=START_PC.
//  6 rst_n low during EXECUTE and during FETCH -> all outputs at reset values same cycle,
//    Start in EXECUTE ignored.

Source files
------------

// File: rtl/gpu_core_pkg.sv
// Shared core types: FSM state encoding used by the sequencer, decoder and LSU.
package gpu_core_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    UPDATE  = 3'd4,
    DONE    = 3'd5
  } core_state_t;

endpackage

// File: rtl/PC_MuxTwo.sv
// Next-PC select: branch target when sel_i is set, otherwise PC+1.
module PC_MuxTwo #(
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                sel_i,
  input  logic [PC_WIDTH-1:0] pc_plus_i,
  input  logic [PC_WIDTH-1:0] branch_i,
  output logic [PC_WIDTH-1:0] next_pc_o
);

  assign next_pc_o = sel_i ? branch_i : pc_plus_i;

endmodule

// File: rtl/pc_sequencer.sv
// Per-core instruction sequencer: owns the PC and steps FETCH/DECODE/EXECUTE/UPDATE.
module pc_sequencer
  import gpu_core_pkg::*;
#(
  parameter int unsigned          PC_WIDTH    = 8,
  parameter int unsigned          INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  START_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Start,
  output logic                   FetchReq,
  output logic [PC_WIDTH-1:0]    FetchAddr,
  input  logic                   FetchValid,
  input  logic [INSTR_WIDTH-1:0] FetchInstr,
  output logic [INSTR_WIDTH-1:0] Instr,
  input  logic                   IsBranch,
  input  logic                   BranchTaken,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  input  logic                   IsRet,
  input  logic                   ExecDone,
  output logic                   PCMux,
  output logic [PC_WIDTH-1:0]    Branch,
  output logic [PC_WIDTH-1:0]    CurrentPCPlus,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  output logic                   Done,
  output logic [2:0]             State
);

  core_state_t            state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    branch_q, branch_d;
  logic                   take_q, take_d;
  logic [PC_WIDTH-1:0]    next_pc;
  logic [PC_WIDTH-1:0]    pc_plus;

  assign pc_plus = pc_q + PC_WIDTH'(1);

  PC_MuxTwo #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_mux (
    .sel_i     (PCMux),
    .pc_plus_i (pc_plus),
    .branch_i  (branch_q),
    .next_pc_o (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= START_PC;
      instr_q  <= '0;
      branch_q <= '0;
      take_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      branch_q <= branch_d;
      take_q   <= take_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    branch_d = branch_q;
    take_d   = take_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          pc_d    = START_PC;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (FetchValid) begin
          instr_d = FetchInstr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        // Branch outcome is re-sampled every cycle; the last EXECUTE cycle wins.
        branch_d = BranchTarget;
        take_d   = IsBranch & BranchTaken;
        if (ExecDone) state_d = UPDATE;
      end
      UPDATE: begin
        pc_d    = next_pc;
        take_d  = 1'b0;
        state_d = IsRet ? DONE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign FetchReq      = (state_q == FETCH);
  assign FetchAddr     = pc_q;
  assign Instr         = instr_q;
  assign PCMux         = (state_q == UPDATE) && take_q;
  assign Branch        = branch_q;
  assign CurrentPCPlus = pc_plus;
  assign CurrentPC     = pc_q;
  assign Done          = (state_q == DONE);
  assign State         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PCs and states.
module tb_pc_sequencer;
  import gpu_core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        Start;
  logic        FetchReq;
  logic [7:0]  FetchAddr;
  logic        FetchValid;
  logic [15:0] FetchInstr;
  logic [15:0] Instr;
  logic        IsBranch;
  logic        BranchTaken;
  logic [7:0]  BranchTarget;
  logic        IsRet;
  logic        ExecDone;
  logic        PCMux;
  logic [7:0]  Branch;
  logic [7:0]  CurrentPCPlus;
  logic [7:0]  CurrentPC;
  logic        Done;
  logic [2:0]  State;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Start         (Start),
    .FetchReq      (FetchReq),
    .FetchAddr     (FetchAddr),
    .FetchValid    (FetchValid),
    .FetchInstr    (FetchInstr),
    .Instr         (Instr),
    .IsBranch      (IsBranch),
    .BranchTaken   (BranchTaken),
    .BranchTarget  (BranchTarget),
    .IsRet         (IsRet),
    .ExecDone      (ExecDone),
    .PCMux         (PCMux),
    .Branch        (Branch),
    .CurrentPCPlus (CurrentPCPlus),
    .CurrentPC     (CurrentPC),
    .Done          (Done),
    .State         (State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_state"}, 32'(State), 32'(IDLE));
    check_eq({tag, "_pc"}, 32'(CurrentPC), 32'h0);
    check_eq({tag, "_instr"}, 32'(Instr), 32'h0);
    check_eq({tag, "_branch"}, 32'(Branch), 32'h0);
    check_eq({tag, "_pcmux"}, 32'(PCMux), 32'h0);
    check_eq({tag, "_fetchreq"}, 32'(FetchReq), 32'h0);
    check_eq({tag, "_done"}, 32'(Done), 32'h0);
  endtask

  // Drives one instruction from FETCH through UPDATE; fd/ed are stall cycles.
  task automatic run_instr(input logic [7:0] pc, input logic [15:0] ins,
                           input logic br, input logic tk, input logic [7:0] tgt,
                           input logic ret, input int fd, input int ed,
                           input logic [7:0] nxt);
    int c0;
    c0 = cyc;
    check_eq("fetch_state", 32'(State), 32'(FETCH));
    check_eq("fetch_req", 32'(FetchReq), 32'h1);
    check_eq("fetch_addr", 32'(FetchAddr), 32'(pc));
    for (int i = 0; i < fd; i++) begin
      step();
      check_eq("fetch_hold_state", 32'(State), 32'(FETCH));
      check_eq("fetch_hold_req", 32'(FetchReq), 32'h1);
      check_eq("fetch_hold_addr", 32'(FetchAddr), 32'(pc));
    end
    FetchValid = 1'b1;
    FetchInstr = ins;
    step();
    FetchValid = 1'b0;
    FetchInstr = 16'hDEAD;
    check_eq("decode_state", 32'(State), 32'(DECODE));
    check_eq("decode_instr", 32'(Instr), 32'(ins));
    check_eq("decode_fetchreq", 32'(FetchReq), 32'h0);
    check_eq("decode_pcmux", 32'(PCMux), 32'h0);
    IsBranch = br;
    IsRet    = ret;
    step();
    check_eq("exec_state", 32'(State), 32'(EXECUTE));
    BranchTaken  = tk;
    BranchTarget = tgt;
    ExecDone     = (ed == 0);
    for (int i = 0; i < ed; i++) begin
      step();
      check_eq("exec_hold_state", 32'(State), 32'(EXECUTE));
      check_eq("exec_hold_pcmux", 32'(PCMux), 32'h0);
      if (i == ed - 1) ExecDone = 1'b1;
    end
    step();
    ExecDone = 1'b0;
    check_eq("update_state", 32'(State), 32'(UPDATE));
    check_eq("update_pcmux", 32'(PCMux), 32'(br & tk));
    check_eq("update_branch", 32'(Branch), 32'(tgt));
    check_eq("update_pcplus", 32'(CurrentPCPlus), 32'(8'(pc + 8'd1)));
    step();
    IsRet       = 1'b0;
    IsBranch    = 1'b0;
    BranchTaken = 1'b0;
    check_eq("next_state", 32'(State), ret ? 32'(DONE) : 32'(FETCH));
    check_eq("next_pc", 32'(CurrentPC), 32'(nxt));
    check_eq("next_pcmux", 32'(PCMux), 32'h0);
    check_eq("instr_cycles", 32'(cyc - c0), 32'(4 + fd + ed));
  endtask

  initial begin
    rst_n = 1'b0; Start = 1'b0; FetchValid = 1'b0; FetchInstr = '0;
    IsBranch = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    IsRet = 1'b0; ExecDone = 1'b0;
    #12;
    check_reset("reset");
    rst_n = 1'b1;
    step();
    check_eq("idle_hold", 32'(State), 32'(IDLE));
    FetchValid = 1'b1;
    step();
    FetchValid = 1'b0;
    check_eq("idle_ignore_valid", 32'(State), 32'(IDLE));
    Start = 1'b1;
    step();
    Start = 1'b0;

    // straight-line code, then branches walking PC to 5, 0x20, 0x21, 0xFF
    run_instr(8'h00, 16'h1001, 0, 0, 8'h00, 0, 0, 0, 8'h01);
    run_instr(8'h01, 16'h1002, 0, 0, 8'h00, 0, 0, 0, 8'h02);
    run_instr(8'h02, 16'h1003, 0, 0, 8'h00, 0, 0, 0, 8'h03);
    run_instr(8'h03, 16'h2004, 1, 1, 8'h05, 0, 0, 0, 8'h05);
    run_instr(8'h05, 16'h2005, 1, 1, 8'h20, 0, 0, 0, 8'h20);
    run_instr(8'h20, 16'h2006, 1, 0, 8'h40, 0, 0, 0, 8'h21);
    run_instr(8'h21, 16'h2007, 1, 1, 8'hFF, 0, 0, 0, 8'hFF);
    run_instr(8'hFF, 16'h1008, 0, 0, 8'h77, 0, 0, 0, 8'h00);
    // taken flag without IsBranch must not redirect
    run_instr(8'h00, 16'h1009, 0, 1, 8'h99, 0, 0, 0, 8'h01);
    run_instr(8'h01, 16'h100A, 0, 0, 8'h00, 0, 5, 3, 8'h02);
    run_instr(8'h02, 16'h200B, 1, 1, 8'h03, 0, 0, 0, 8'h03);
    run_instr(8'h03, 16'hF00C, 0, 0, 8'h00, 1, 0, 0, 8'h04);

    check_eq("done_flag", 32'(Done), 32'h1);
    for (int i = 0; i < 3; i++) begin
      FetchValid = 1'b1;
      step();
      check_eq("done_sticky", 32'(Done), 32'h1);
      check_eq("done_fetchreq", 32'(FetchReq), 32'h0);
      check_eq("done_pc", 32'(CurrentPC), 32'h04);
    end
    FetchValid = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("restart_done", 32'(Done), 32'h0);
    check_eq("restart_addr", 32'(FetchAddr), 32'h00);

    // branch and return together: redirect still applies, then halt
    run_instr(8'h00, 16'hF00D, 1, 1, 8'h10, 1, 0, 0, 8'h10);
    check_eq("brret_done", 32'(Done), 32'h1);
    Start = 1'b1;
    step();
    Start = 1'b0;

    // reset during EXECUTE after a Start that must be ignored there
    run_instr(8'h00, 16'h200E, 1, 1, 8'h33, 0, 0, 0, 8'h33);
    FetchValid = 1'b1;
    FetchInstr = 16'hABCD;
    step();
    FetchValid = 1'b0;
    step();
    check_eq("pre_rst_exec", 32'(State), 32'(EXECUTE));
    IsBranch = 1'b1; BranchTaken = 1'b1; BranchTarget = 8'h44;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("exec_start_ignored", 32'(State), 32'(EXECUTE));
    check_eq("exec_start_pc", 32'(CurrentPC), 32'h33);
    rst_n = 1'b0;
    #1;
    check_reset("rst_exec");
    IsBranch = 1'b0; BranchTaken = 1'b0;
    step();
    rst_n = 1'b1;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("rst_fetch_pre", 32'(FetchReq), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset("rst_fetch");
    step();
    rst_n = 1'b1;
    step();
    check_eq("post_rst_idle", 32'(State), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
